// File: rtl/ram_if_pkg.sv
// rtl/ram_if_pkg.sv - shared types and defaults for the RAM-side responder
//
// Contents:
//   ram_state_t      responder FSM states {IDLE, BUSY, ACK}
//   RAM_ADDR_W       default byte-address width (13 -> 8 KiB)
//   RAM_DATA_W       default data width in bits
//   RAM_LATENCY_DEF  default request-accept to rack-rise latency in edges
//   cnt_width()      width of a down-counter that must hold latency-1

package ram_if_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    ACK  = 2'd2
  } ram_state_t;

  localparam int RAM_ADDR_W      = 13;
  localparam int RAM_DATA_W      = 8;
  localparam int RAM_LATENCY_DEF = 4;

  // A latency of 1 still needs a 1-bit counter (it just stays at 0).
  function automatic int cnt_width(input int latency);
    return (latency > 1) ? $clog2(latency) : 1;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - 1-bit two-flop synchroniser with async active-high reset
//
// Ports:
//   clk  in   destination clock
//   rst  in   asynchronous, active-high reset; both flops clear to 0
//   d    in   asynchronous input
//   q    out  synchronised output, 2 clk edges behind d

module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/ram_responder.sv
// rtl/ram_responder.sv - byte-wide backing memory answering four-phase requests
//
// Optional feature macro: RAM_RESP_SYNC_EN (avalid passes through sync_2ff).
//
// Ports:
//   ram_clk  in   clock; all state updates on posedge
//   areset   in   asynchronous, active-high reset (memory contents kept)
//   avalid   in   request valid; held high by the initiator until rack is seen
//   rnw      in   1 = read, 0 = write; sampled at accept
//   raddr    in   [ADDR_W-1:0] byte address; sampled at accept
//   rwdata   in   [DATA_W-1:0] write data; sampled at accept
//   rrdata   out  [DATA_W-1:0] read data; valid while rack=1 on a read
//   rack     out  acknowledge; rises LATENCY edges after accept, held until avalid drops

module ram_responder
  import ram_if_pkg::*;
#(
  parameter int ADDR_W  = RAM_ADDR_W,
  parameter int DATA_W  = RAM_DATA_W,
  parameter int LATENCY = RAM_LATENCY_DEF
) (
  input  logic              ram_clk,
  input  logic              areset,
  input  logic              avalid,
  input  logic              rnw,
  input  logic [ADDR_W-1:0] raddr,
  input  logic [DATA_W-1:0] rwdata,
  output logic [DATA_W-1:0] rrdata,
  output logic              rack
);

  localparam int CNT_W = cnt_width(LATENCY);
  localparam int DEPTH = 2 ** ADDR_W;

  ram_state_t        state;
  logic [CNT_W-1:0]  cnt;
  logic              rnw_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              avalid_i;

  logic [DATA_W-1:0] mem [DEPTH];

`ifdef RAM_RESP_SYNC_EN
  sync_2ff u_avalid_sync (
    .clk (ram_clk),
    .rst (areset),
    .d   (avalid),
    .q   (avalid_i)
  );
`else
  assign avalid_i = avalid;
`endif

  // Completion happens on the edge where the BUSY countdown has reached zero.
  logic done;
  assign done = (state == BUSY) && (cnt == '0);

  always_ff @(posedge ram_clk or posedge areset) begin
    if (areset) begin
      state   <= IDLE;
      cnt     <= '0;
      rack    <= 1'b0;
      rrdata  <= '0;
      rnw_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (avalid_i) begin
            rnw_q   <= rnw;
            addr_q  <= raddr;
            wdata_q <= rwdata;
            cnt     <= CNT_W'(LATENCY - 1);
            state   <= BUSY;
          end
        end
        BUSY: begin
          if (cnt == '0) begin
            if (rnw_q) begin
              rrdata <= mem[addr_q];
            end
            rack  <= 1'b1;
            state <= ACK;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        ACK: begin
          // Return to IDLE only; a new accept needs a further edge, which
          // keeps the handshake strictly four-phase.
          if (!avalid_i) begin
            rack  <= 1'b0;
            state <= IDLE;
          end
        end
        default: begin
          rack  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  // Storage has no reset. Because the FSM resets asynchronously, a write
  // still counting down in BUSY is dropped without touching memory.
  always_ff @(posedge ram_clk) begin
    if (done && !rnw_q) begin
      mem[addr_q] <= wdata_q;
    end
  end

endmodule

// File: tb/tb_ram_responder.sv
// tb/tb_ram_responder.sv - scoreboard bench for ram_responder

module tb_ram_responder;

  localparam int AW      = 13;
  localparam int DW      = 8;
  localparam int LAT     = 4;
  localparam int TIMEOUT = 60;
`ifdef RAM_RESP_SYNC_EN
  localparam int SYNC_DLY = 2;
`else
  localparam int SYNC_DLY = 0;
`endif

  logic          ram_clk = 1'b0;
  logic          areset  = 1'b1;
  logic          avalid  = 1'b0;
  logic          rnw     = 1'b0;
  logic [AW-1:0] raddr   = '0;
  logic [DW-1:0] rwdata  = '0;
  logic [DW-1:0] rrdata;
  logic          rack;

  ram_responder #(.ADDR_W(AW), .DATA_W(DW), .LATENCY(LAT)) dut (
    .ram_clk (ram_clk),
    .areset  (areset),
    .avalid  (avalid),
    .rnw     (rnw),
    .raddr   (raddr),
    .rwdata  (rwdata),
    .rrdata  (rrdata),
    .rack    (rack)
  );

  initial forever #5 ram_clk = ~ram_clk;

  int edge_n = 0;
  always @(posedge ram_clk) edge_n++;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    bit            is_read;
    logic [DW-1:0] data;
    int            rise;
  } exp_t;

  exp_t          sb[$];
  logic [DW-1:0] model [int];
  int            written[$];

  // Monitor: every rising rack retires the oldest outstanding request.
  logic rack_prev = 1'b0;
  always @(negedge ram_clk) begin
    if (!areset && rack && !rack_prev) begin
      if (sb.size() == 0) begin
        check("unexpected_rack", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("rack_rise_edge", edge_n, e.rise);
        if (e.is_read) check("read_data", rrdata, e.data);
      end
    end
    rack_prev = rack;
  end

  // One request. hold=1 leaves avalid high after rack (caller finishes it).
  task automatic do_txn(input bit is_read, input logic [AW-1:0] addr,
                        input logic [DW-1:0] wdata, input bit scramble, input bit hold);
    exp_t e;
    int   acc;
    int   n;
    int   fall_exp;
    @(negedge ram_clk);
    e.is_read = is_read;
    e.data    = is_read ? model[int'(addr)] : '0;
    e.rise    = edge_n + 1 + SYNC_DLY + LAT;
    sb.push_back(e);
    acc    = edge_n + 1 + SYNC_DLY;
    avalid = 1'b1;
    rnw    = is_read;
    raddr  = addr;
    rwdata = wdata;
    n = 0;
    while (!rack && n < TIMEOUT) begin
      @(negedge ram_clk);
      n++;
      if (scramble && edge_n >= acc) begin
        raddr  = AW'($urandom);
        rwdata = DW'($urandom);
        rnw    = 1'($urandom);
      end
    end
    if (!rack) begin
      check("rack_timeout", 32'd0, 32'd1);
      if (sb.size() != 0) void'(sb.pop_back());
      avalid = 1'b0;
      return;
    end
    if (!is_read) begin
      model[int'(addr)] = wdata;
      written.push_back(int'(addr));
    end
    if (hold) return;
    avalid   = 1'b0;
    fall_exp = edge_n + 1 + SYNC_DLY;
    n = 0;
    while (rack && n < TIMEOUT) begin
      @(negedge ram_clk);
      n++;
    end
    check("rack_fall_edge", edge_n, fall_exp);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state.
    repeat (3) @(negedge ram_clk);
    check("reset_rack", rack, 0);
    check("reset_rrdata", rrdata, 0);
    areset = 1'b0;

    // Basic write then read back-to-back.
    do_txn(1'b0, 13'h0010, 8'hA5, 1'b0, 1'b0);
    do_txn(1'b1, 13'h0010, 8'h00, 1'b0, 1'b0);

    // Address extremes, no aliasing.
    do_txn(1'b0, 13'h1FFF, 8'h3C, 1'b0, 1'b0);
    do_txn(1'b0, 13'h0000, 8'hC3, 1'b0, 1'b0);
    do_txn(1'b1, 13'h1FFF, 8'h00, 1'b0, 1'b0);
    do_txn(1'b1, 13'h0000, 8'h00, 1'b0, 1'b0);

    // Inputs scrambled after accept must be ignored.
    do_txn(1'b0, 13'h0020, 8'h5A, 1'b1, 1'b0);
    do_txn(1'b1, 13'h0020, 8'h00, 1'b1, 1'b0);
    do_txn(1'b1, 13'h0010, 8'h00, 1'b1, 1'b0);

    // Reset in the middle of a write: memory keeps the old byte.
    do_txn(1'b0, 13'h0100, 8'h11, 1'b0, 1'b0);
    begin
      int acc;
      int n;
      @(negedge ram_clk);
      avalid = 1'b1;
      rnw    = 1'b0;
      raddr  = 13'h0100;
      rwdata = 8'h77;
      acc    = edge_n + 1 + SYNC_DLY;
      n = 0;
      // cnt is 1 after the second edge past accept.
      while (edge_n < acc + 2 && n < TIMEOUT) begin
        @(negedge ram_clk);
        n++;
      end
      check("no_rack_before_abort", rack, 0);
      avalid = 1'b0;
      areset = 1'b1;
      #1;
      check("abort_rack", rack, 0);
      @(negedge ram_clk);
      areset = 1'b0;
    end
    do_txn(1'b1, 13'h0100, 8'h00, 1'b0, 1'b0);

    // Asynchronous reset while a read is acknowledged clears outputs at once.
    do_txn(1'b1, 13'h0010, 8'h00, 1'b0, 1'b1);
    #2;
    areset = 1'b1;
    #1;
    check("async_reset_rack", rack, 0);
    check("async_reset_rrdata", rrdata, 0);
    avalid = 1'b0;
    @(negedge ram_clk);
    areset = 1'b0;
    do_txn(1'b1, 13'h0010, 8'h00, 1'b0, 1'b0);

    // Randomised traffic against the byte-array model.
    for (int i = 0; i < 60; i++) begin
      bit            rd;
      logic [AW-1:0] a;
      rd = ($urandom_range(0, 1) == 1) && (written.size() != 0);
      if (rd) a = AW'(written[$urandom_range(0, written.size() - 1)]);
      else    a = AW'($urandom);
      do_txn(rd, a, DW'($urandom), 1'($urandom), 1'b0);
    end

    repeat (5) @(negedge ram_clk);
    check("scoreboard_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
